// File: rtl/ex_pipe_pkg.sv
// Shared widths, encodings and payload layout for the EX->MEM pipeline register.
package ex_pipe_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned REG_W    = 5;
    localparam int unsigned MEMOP_W  = 2;
    localparam int unsigned CTRLOP_W = 2;
    localparam int unsigned EXP_W    = 3;
    localparam int unsigned CP2_N    = 3;

    localparam logic [MEMOP_W-1:0]  MEMOP_NOP    = MEMOP_W'(0);
    localparam logic [CTRLOP_W-1:0] CTRLOP_NOP   = CTRLOP_W'(0);
    localparam logic [EXP_W-1:0]    EXP_NOEXP    = EXP_W'(0);
    localparam logic [EXP_W-1:0]    EXP_OVERFLOW = EXP_W'(3);

    typedef struct packed {
        logic [ADDR_W-1:0]   pc;
        logic                br_flag;
        logic [MEMOP_W-1:0]  mem_op;
        logic [DATA_W-1:0]   mem_wr_data;
        logic [CTRLOP_W-1:0] ctrl_op;
        logic [REG_W-1:0]    dst_addr;
        logic                gpr_we_;
        logic [EXP_W-1:0]    exp_code;
        logic [DATA_W-1:0]   out;
        logic [CP2_N-1:0]    cp2_sel;
        logic [DATA_W-1:0]   cp2_wr_data;
    } ex_payload_t;

    localparam int unsigned PAY_W = $bits(ex_payload_t);

    // Bubble payload: no memory op, no register write, no exception.
    localparam ex_payload_t PAY_RST = '{
        pc:          '0,
        br_flag:     1'b0,
        mem_op:      MEMOP_NOP,
        mem_wr_data: '0,
        ctrl_op:     CTRLOP_NOP,
        dst_addr:    '0,
        gpr_we_:     1'b1,
        exp_code:    EXP_NOEXP,
        out:         '0,
        cp2_sel:     '0,
        cp2_wr_data: '0
    };

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_FULL  = 2'd1,
        BUF_BOTH  = 2'd2
    } buf_state_e;

endpackage

// File: rtl/ex_pipe_reg_if.sv
// EX->MEM stage boundary: upstream instruction bundle, control strobes and registered EX payload.
interface ex_pipe_reg_if;
    import ex_pipe_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic                flush;
    logic                int_detect;
    logic [EXP_W-1:0]    int_type;
    logic [DATA_W-1:0]   alu_out;
    logic                alu_of;
    logic [ADDR_W-1:0]   id_pc;
    logic                id_br_flag;
    logic [MEMOP_W-1:0]  id_mem_op;
    logic [DATA_W-1:0]   id_mem_wr_data;
    logic [CTRLOP_W-1:0] id_ctrl_op;
    logic [REG_W-1:0]    id_dst_addr;
    logic                id_gpr_we_;
    logic [EXP_W-1:0]    id_exp_code;
    logic [CP2_N-1:0]    id_cp2_sel;
    logic [DATA_W-1:0]   id_cp2_wr_data;

    logic                ex_valid;
    logic                ex_ready;
    logic [ADDR_W-1:0]   ex_pc;
    logic                ex_br_flag;
    logic [MEMOP_W-1:0]  ex_mem_op;
    logic [DATA_W-1:0]   ex_mem_wr_data;
    logic [CTRLOP_W-1:0] ex_ctrl_op;
    logic [REG_W-1:0]    ex_dst_addr;
    logic                ex_gpr_we_;
    logic [EXP_W-1:0]    ex_exp_code;
    logic [DATA_W-1:0]   ex_out;
    logic [CP2_N-1:0]    ex_cp2_sel;
    logic [DATA_W-1:0]   ex_cp2_wr_data;

    // Upstream/EX-side driver view.
    modport master (
        output in_valid, flush, int_detect, int_type, alu_out, alu_of,
               id_pc, id_br_flag, id_mem_op, id_mem_wr_data, id_ctrl_op,
               id_dst_addr, id_gpr_we_, id_exp_code, id_cp2_sel, id_cp2_wr_data,
               ex_ready,
        input  in_ready, ex_valid, ex_pc, ex_br_flag, ex_mem_op, ex_mem_wr_data,
               ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out,
               ex_cp2_sel, ex_cp2_wr_data
    );

    // Pipeline register view.
    modport slave (
        input  in_valid, flush, int_detect, int_type, alu_out, alu_of,
               id_pc, id_br_flag, id_mem_op, id_mem_wr_data, id_ctrl_op,
               id_dst_addr, id_gpr_we_, id_exp_code, id_cp2_sel, id_cp2_wr_data,
               ex_ready,
        output in_ready, ex_valid, ex_pc, ex_br_flag, ex_mem_op, ex_mem_wr_data,
               ex_ctrl_op, ex_dst_addr, ex_gpr_we_, ex_exp_code, ex_out,
               ex_cp2_sel, ex_cp2_wr_data
    );

endinterface

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready buffer: one main entry plus an optional skid entry.
// SKID=1 gives a registered in_ready; SKID=0 is a single entry with combinational ready.
module pipe_skid_buf
    import ex_pipe_pkg::*;
#(
    parameter int unsigned W       = PAY_W,
    parameter int unsigned SKID    = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_e   state_q;
    buf_state_e   state_d;
    logic         in_ready_q;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;

    logic         acc;
    logic         pop;
    logic         ld_main;
    logic         main_from_skid;
    logic         ld_skid;

    // State register; in_ready is precomputed from the state being entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BUF_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != BUF_BOTH);
        end
    end

    // Next state; flush empties the buffer regardless of handshakes.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = BUF_EMPTY;
        end else begin
            unique case (state_q)
                BUF_EMPTY: if (acc) state_d = BUF_FULL;
                BUF_FULL: begin
                    if (acc && !pop && (SKID != 0)) state_d = BUF_BOTH;
                    else if (!acc && pop)           state_d = BUF_EMPTY;
                end
                BUF_BOTH:  if (pop) state_d = BUF_FULL;
                default:   state_d = BUF_EMPTY;
            endcase
        end
    end

    // Handshake decode and entry load strobes.
    always_comb begin
        out_valid      = (state_q != BUF_EMPTY);
        in_ready       = (SKID != 0) ? in_ready_q : ((state_q == BUF_EMPTY) || out_ready);
        acc            = in_valid && in_ready;
        pop            = out_valid && out_ready;
        ld_main        = 1'b0;
        main_from_skid = 1'b0;
        ld_skid        = 1'b0;
        unique case (state_q)
            BUF_EMPTY: ld_main = acc;
            BUF_FULL: begin
                if (acc && pop)  ld_main = 1'b1;
                else if (acc)    ld_skid = 1'b1;
            end
            BUF_BOTH:  main_from_skid = pop;
            default: ;
        endcase
    end

    // Entry storage: the head only changes on load, so it is stable under backpressure.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else begin
            if (ld_main)             main_q <= in_data;
            else if (main_from_skid) main_q <= skid_q;
            if (ld_skid)             skid_q <= in_data;
        end
    end

    assign out_data = main_q;

endmodule

// File: rtl/ex_pipe_reg.sv
// EX->MEM pipeline register: squashes the incoming bundle at capture, then buffers it
// behind a valid/ready handshake.
module ex_pipe_reg
    import ex_pipe_pkg::*;
#(
    parameter int unsigned SKID = 1
) (
    input  logic          clk,
    input  logic          reset,
    ex_pipe_reg_if.slave  bus
);

    ex_payload_t      cap_pay;
    ex_payload_t      head_pay;
    logic [PAY_W-1:0] cap_bits;
    logic [PAY_W-1:0] head_bits;
    logic             buf_in_ready;
    logic             buf_out_valid;

    // Squash priority: interrupt tag, then overflow, else a straight copy.
    always_comb begin
        cap_pay         = PAY_RST;
        cap_pay.pc      = bus.id_pc;
        cap_pay.br_flag = bus.id_br_flag;
        if (bus.int_detect) begin
            cap_pay.exp_code = bus.int_type;
        end else if (bus.alu_of) begin
            cap_pay.exp_code = EXP_OVERFLOW;
        end else begin
            cap_pay.mem_op      = bus.id_mem_op;
            cap_pay.mem_wr_data = bus.id_mem_wr_data;
            cap_pay.ctrl_op     = bus.id_ctrl_op;
            cap_pay.dst_addr    = bus.id_dst_addr;
            cap_pay.gpr_we_     = bus.id_gpr_we_;
            cap_pay.exp_code    = bus.id_exp_code;
            cap_pay.out         = bus.alu_out;
            cap_pay.cp2_sel     = bus.id_cp2_sel;
            cap_pay.cp2_wr_data = bus.id_cp2_wr_data;
        end
    end

    assign cap_bits = cap_pay;

    pipe_skid_buf #(
        .W       (PAY_W),
        .SKID    (SKID),
        .RST_VAL (PAY_RST)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.flush),
        .in_valid  (bus.in_valid),
        .in_ready  (buf_in_ready),
        .in_data   (cap_bits),
        .out_valid (buf_out_valid),
        .out_ready (bus.ex_ready),
        .out_data  (head_bits)
    );

    assign head_pay = ex_payload_t'(head_bits);

    assign bus.in_ready       = buf_in_ready;
    assign bus.ex_valid       = buf_out_valid;
    assign bus.ex_pc          = head_pay.pc;
    assign bus.ex_br_flag     = head_pay.br_flag;
    assign bus.ex_mem_op      = head_pay.mem_op;
    assign bus.ex_mem_wr_data = head_pay.mem_wr_data;
    assign bus.ex_ctrl_op     = head_pay.ctrl_op;
    assign bus.ex_dst_addr    = head_pay.dst_addr;
    assign bus.ex_gpr_we_     = head_pay.gpr_we_;
    assign bus.ex_exp_code    = head_pay.exp_code;
    assign bus.ex_out         = head_pay.out;
    assign bus.ex_cp2_sel     = head_pay.cp2_sel;
    assign bus.ex_cp2_wr_data = head_pay.cp2_wr_data;

endmodule

// File: tb/tb_ex_pipe_reg.sv
// Bench for ex_pipe_reg: scoreboarded SKID=1 instance plus a SKID=0 instance for ready timing.
module tb_ex_pipe_reg;
    import ex_pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ex_pipe_reg_if bus1 ();
    ex_pipe_reg_if bus0 ();

    ex_pipe_reg #(.SKID(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    ex_pipe_reg #(.SKID(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    int checks = 0;
    int errors = 0;

    ex_payload_t sb_q[$];
    int          occ = 0;
    logic        mdl_ready;
    logic        mdl_acc;
    logic        mdl_pop;
    ex_payload_t got_pay;
    ex_payload_t exp_pay;
    logic [ADDR_W-1:0] pc_next;

    // Expected captured entry for the current bus1 inputs.
    function automatic ex_payload_t expect_pay();
        ex_payload_t e;
        e.pc          = bus1.id_pc;
        e.br_flag     = bus1.id_br_flag;
        e.mem_op      = 2'd0;
        e.mem_wr_data = 32'd0;
        e.ctrl_op     = 2'd0;
        e.dst_addr    = 5'd0;
        e.gpr_we_     = 1'b1;
        e.out         = 32'd0;
        e.cp2_sel     = 3'd0;
        e.cp2_wr_data = 32'd0;
        if (bus1.int_detect)  e.exp_code = bus1.int_type;
        else if (bus1.alu_of) e.exp_code = 3'd3;
        else begin
            e.exp_code    = bus1.id_exp_code;
            e.mem_op      = bus1.id_mem_op;
            e.mem_wr_data = bus1.id_mem_wr_data;
            e.ctrl_op     = bus1.id_ctrl_op;
            e.dst_addr    = bus1.id_dst_addr;
            e.gpr_we_     = bus1.id_gpr_we_;
            e.out         = bus1.alu_out;
            e.cp2_sel     = bus1.id_cp2_sel;
            e.cp2_wr_data = bus1.id_cp2_wr_data;
        end
        return e;
    endfunction

    // Occupancy model and scoreboard, sampled mid-cycle on stable signals.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            occ = 0;
        end else begin
            mdl_ready = (occ != 2);
            checks++;
            if (bus1.in_ready !== mdl_ready) begin
                errors++;
                $display("FAIL mon_in_ready t=%0t got %b exp %b", $time, bus1.in_ready, mdl_ready);
            end
            checks++;
            if (bus1.ex_valid !== (occ != 0)) begin
                errors++;
                $display("FAIL mon_ex_valid t=%0t got %b exp %b", $time, bus1.ex_valid, occ != 0);
            end
            mdl_pop = (occ != 0) && bus1.ex_ready;
            mdl_acc = bus1.in_valid && mdl_ready;
            if (mdl_pop) begin
                got_pay.pc          = bus1.ex_pc;
                got_pay.br_flag     = bus1.ex_br_flag;
                got_pay.mem_op      = bus1.ex_mem_op;
                got_pay.mem_wr_data = bus1.ex_mem_wr_data;
                got_pay.ctrl_op     = bus1.ex_ctrl_op;
                got_pay.dst_addr    = bus1.ex_dst_addr;
                got_pay.gpr_we_     = bus1.ex_gpr_we_;
                got_pay.exp_code    = bus1.ex_exp_code;
                got_pay.out         = bus1.ex_out;
                got_pay.cp2_sel     = bus1.ex_cp2_sel;
                got_pay.cp2_wr_data = bus1.ex_cp2_wr_data;
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_underflow t=%0t got pc %h exp no entry", $time, bus1.ex_pc);
                end else begin
                    exp_pay = sb_q.pop_front();
                    if (got_pay !== exp_pay) begin
                        errors++;
                        $display("FAIL sb_payload t=%0t got %h exp %h", $time, got_pay, exp_pay);
                    end
                end
            end
            if (bus1.flush) begin
                sb_q.delete();
                occ = 0;
            end else begin
                if (mdl_acc) sb_q.push_back(expect_pay());
                occ = occ + (mdl_acc ? 1 : 0) - (mdl_pop ? 1 : 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [ADDR_W-1:0] pc, input logic of,
                         input logic intd, input logic [EXP_W-1:0] it);
        bus1.in_valid       = v;
        bus1.id_pc          = pc;
        bus1.alu_of         = of;
        bus1.int_detect     = intd;
        bus1.int_type       = it;
        bus1.alu_out        = DATA_W'($urandom);
        bus1.id_br_flag     = 1'($urandom);
        bus1.id_mem_op      = MEMOP_W'($urandom);
        bus1.id_mem_wr_data = DATA_W'($urandom);
        bus1.id_ctrl_op     = CTRLOP_W'($urandom);
        bus1.id_dst_addr    = REG_W'($urandom);
        bus1.id_gpr_we_     = 1'($urandom);
        bus1.id_exp_code    = EXP_W'($urandom);
        bus1.id_cp2_sel     = CP2_N'($urandom);
        bus1.id_cp2_wr_data = DATA_W'($urandom);
    endtask

    task automatic test_reset();
        bus1.ex_ready = 1'b0;
        drive(1'b1, 30'h1, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 30'h2, 1'b0, 1'b0, 3'd0);
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        drive(1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (bus1.ex_valid !== 1'b0) begin errors++; $display("FAIL reset_ex_valid got %b exp 0", bus1.ex_valid); end
        checks++;
        if (bus1.ex_gpr_we_ !== 1'b1) begin errors++; $display("FAIL reset_gpr_we got %b exp 1", bus1.ex_gpr_we_); end
        checks++;
        if (bus1.ex_exp_code !== 3'd0) begin errors++; $display("FAIL reset_exp got %0d exp 0", bus1.ex_exp_code); end
        checks++;
        if (bus1.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", bus1.in_ready); end
        checks++;
        if (bus1.ex_pc !== 30'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", bus1.ex_pc); end
        checks++;
        if (bus0.ex_gpr_we_ !== 1'b1 || bus0.ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_skid0 got we_=%b valid=%b exp we_=1 valid=0", bus0.ex_gpr_we_, bus0.ex_valid);
        end
    endtask

    task automatic test_stream();
        logic [ADDR_W-1:0] pc;
        bus1.ex_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            pc = ADDR_W'(32'h10 + i);
            drive(1'b1, pc, 1'b0, 1'b0, 3'd0);
            step();
            checks++;
            if (bus1.ex_valid !== 1'b1 || bus1.ex_pc !== pc) begin
                errors++;
                $display("FAIL stream_%0d got valid=%b pc=%h exp valid=1 pc=%h", i, bus1.ex_valid, bus1.ex_pc, pc);
            end
        end
        drive(1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        step();
        checks++;
        if (bus1.ex_valid !== 1'b0) begin errors++; $display("FAIL stream_drain got %b exp 0", bus1.ex_valid); end
    endtask

    task automatic test_backpressure();
        bus1.ex_ready = 1'b0;
        drive(1'b1, 30'h20, 1'b0, 1'b0, 3'd0);
        step();
        checks++;
        if (bus1.in_ready !== 1'b1 || bus1.ex_pc !== 30'h20) begin
            errors++;
            $display("FAIL bp_first got ready=%b pc=%h exp ready=1 pc=20", bus1.in_ready, bus1.ex_pc);
        end
        drive(1'b1, 30'h21, 1'b0, 1'b0, 3'd0);
        step();
        checks++;
        if (bus1.in_ready !== 1'b0 || bus1.ex_pc !== 30'h20) begin
            errors++;
            $display("FAIL bp_full got ready=%b pc=%h exp ready=0 pc=20", bus1.in_ready, bus1.ex_pc);
        end
        drive(1'b1, 30'h22, 1'b0, 1'b0, 3'd0);
        step();
        checks++;
        if (bus1.in_ready !== 1'b0 || bus1.ex_pc !== 30'h20) begin
            errors++;
            $display("FAIL bp_hold got ready=%b pc=%h exp ready=0 pc=20", bus1.in_ready, bus1.ex_pc);
        end
        drive(1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        bus1.ex_ready = 1'b1;
        step();
        checks++;
        if (bus1.ex_valid !== 1'b1 || bus1.ex_pc !== 30'h21 || bus1.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain got valid=%b pc=%h ready=%b exp 1/21/1", bus1.ex_valid, bus1.ex_pc, bus1.in_ready);
        end
        step();
        checks++;
        if (bus1.ex_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", bus1.ex_valid); end
    endtask

    task automatic test_squash();
        bus1.ex_ready = 1'b1;
        drive(1'b1, 30'h30, 1'b1, 1'b0, 3'd0);
        bus1.id_dst_addr = 5'd5;
        bus1.id_gpr_we_  = 1'b0;
        step();
        checks++;
        if (bus1.ex_exp_code !== 3'd3 || bus1.ex_dst_addr !== 5'd0 || bus1.ex_gpr_we_ !== 1'b1 || bus1.ex_pc !== 30'h30) begin
            errors++;
            $display("FAIL squash_of got exp=%0d dst=%0d we_=%b pc=%h exp 3/0/1/30",
                     bus1.ex_exp_code, bus1.ex_dst_addr, bus1.ex_gpr_we_, bus1.ex_pc);
        end
        drive(1'b1, 30'h31, 1'b1, 1'b1, 3'd2);
        step();
        checks++;
        if (bus1.ex_exp_code !== 3'd2 || bus1.ex_pc !== 30'h31 || bus1.ex_out !== 32'd0) begin
            errors++;
            $display("FAIL squash_int got exp=%0d pc=%h out=%h exp 2/31/0", bus1.ex_exp_code, bus1.ex_pc, bus1.ex_out);
        end
        drive(1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        step();
    endtask

    task automatic test_flush();
        bus1.ex_ready = 1'b0;
        drive(1'b1, 30'h40, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 30'h41, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 30'h42, 1'b0, 1'b0, 3'd0);
        bus1.flush = 1'b1;
        step();
        bus1.flush = 1'b0;
        checks++;
        if (bus1.ex_valid !== 1'b0 || bus1.in_ready !== 1'b1 || bus1.ex_pc !== 30'h0) begin
            errors++;
            $display("FAIL flush_both got valid=%b ready=%b pc=%h exp 0/1/0", bus1.ex_valid, bus1.in_ready, bus1.ex_pc);
        end
        drive(1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        bus1.ex_ready = 1'b1;
        step();
        checks++;
        if (bus1.ex_valid !== 1'b0) begin errors++; $display("FAIL flush_quiet got %b exp 0", bus1.ex_valid); end
        bus1.ex_ready = 1'b0;
        drive(1'b1, 30'h50, 1'b0, 1'b0, 3'd0);
        step();
        drive(1'b1, 30'h51, 1'b0, 1'b0, 3'd0);
        bus1.flush = 1'b1;
        step();
        bus1.flush = 1'b0;
        drive(1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        checks++;
        if (bus1.ex_valid !== 1'b0 || bus1.ex_gpr_we_ !== 1'b1) begin
            errors++;
            $display("FAIL flush_acc got valid=%b we_=%b exp 0/1", bus1.ex_valid, bus1.ex_gpr_we_);
        end
        step();
        bus1.ex_ready = 1'b1;
    endtask

    task automatic test_back_to_back();
        pc_next = 30'h100;
        for (int i = 0; i < 60; i++) begin
            drive(($urandom % 4) != 0, pc_next, ($urandom % 8) == 0, ($urandom % 8) == 0, EXP_W'($urandom));
            bus1.ex_ready = (($urandom % 3) != 0);
            pc_next = pc_next + 30'd1;
            step();
        end
        drive(1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        bus1.ex_ready = 1'b1;
        for (int i = 0; i < 6 && occ != 0; i++) step();
        checks++;
        if (bus1.ex_valid !== 1'b0 || sb_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_drain got valid=%b pending=%0d exp 0/0", bus1.ex_valid, sb_q.size());
        end
    endtask

    task automatic test_skid0();
        bus0.ex_ready = 1'b0;
        bus0.in_valid = 1'b1;
        bus0.id_pc    = 30'h60;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL s0_empty_ready got %b exp 1", bus0.in_ready); end
        step();
        checks++;
        if (bus0.ex_valid !== 1'b1 || bus0.ex_pc !== 30'h60) begin
            errors++;
            $display("FAIL s0_capture got valid=%b pc=%h exp 1/60", bus0.ex_valid, bus0.ex_pc);
        end
        bus0.in_valid = 1'b0;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b0) begin errors++; $display("FAIL s0_stall_ready got %b exp 0", bus0.in_ready); end
        bus0.ex_ready = 1'b1;
        #1;
        checks++;
        if (bus0.in_ready !== 1'b1) begin errors++; $display("FAIL s0_comb_ready got %b exp 1", bus0.in_ready); end
        bus0.in_valid = 1'b1;
        bus0.id_pc    = 30'h61;
        step();
        checks++;
        if (bus0.ex_valid !== 1'b1 || bus0.ex_pc !== 30'h61) begin
            errors++;
            $display("FAIL s0_reload got valid=%b pc=%h exp 1/61", bus0.ex_valid, bus0.ex_pc);
        end
        bus0.in_valid = 1'b0;
        step();
        checks++;
        if (bus0.ex_valid !== 1'b0) begin errors++; $display("FAIL s0_drain got %b exp 0", bus0.ex_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus1.flush = 1'b0;
        bus1.ex_ready = 1'b1;
        drive(1'b0, 30'h0, 1'b0, 1'b0, 3'd0);
        bus0.in_valid = 1'b0;       bus0.flush = 1'b0;        bus0.int_detect = 1'b0;
        bus0.int_type = 3'd0;       bus0.alu_out = 32'd0;     bus0.alu_of = 1'b0;
        bus0.id_pc = 30'h0;         bus0.id_br_flag = 1'b0;   bus0.id_mem_op = 2'd0;
        bus0.id_mem_wr_data = 32'd0; bus0.id_ctrl_op = 2'd0;  bus0.id_dst_addr = 5'd0;
        bus0.id_gpr_we_ = 1'b1;     bus0.id_exp_code = 3'd0;  bus0.id_cp2_sel = 3'd0;
        bus0.id_cp2_wr_data = 32'd0; bus0.ex_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_squash();
        test_flush();
        test_back_to_back();
        test_skid0();
        step();
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d exp 0", sb_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
